// File: rtl/jogo_pkg.sv
// Shared definitions for the parametrised memory game: state encoding
// (also exported on db_estado) and the one-hot validity helper.
package jogo_pkg;

    typedef enum logic [4:0] {
        ST_INICIAL     = 5'd0,
        ST_PREPARA     = 5'd1,
        ST_MOSTRA      = 5'd2,
        ST_APAGA       = 5'd3,
        ST_ESPERA      = 5'd4,
        ST_REGISTRA    = 5'd5,
        ST_COMPARA     = 5'd6,
        ST_ESPERA_NOVA = 5'd7,
        ST_ESCREVE     = 5'd8,
        ST_PROX_RODADA = 5'd9,
        ST_FIM_ACERTO  = 5'd10,
        ST_FIM_ERRO    = 5'd11,
        ST_FIM_TIMEOUT = 5'd12
    } estado_t;

    localparam int ESTADO_W = 5;
    localparam int MAX_BOTOES = 8;

    // True when exactly one bit is set; callers zero-extend narrower moves.
    function automatic logic eh_one_hot(input logic [MAX_BOTOES-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/jogo_memoria_fd.sv
// Datapath of the memory game: move RAM, round/address counters, LED and
// timeout counters, press edge detector and move comparator (JOGO_TIMEOUT_EN).
module jogo_memoria_fd
    import jogo_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int N_RODADAS       = 16,
    parameter int TIMEOUT_CICLOS  = 3000,
    parameter int TEMPO_LED       = 1000,
    parameter int PRIMEIRA_JOGADA = 0
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [N_BOTOES-1:0]           botoes_i,
    input  logic                          limpa_i,
    input  logic                          escreve_i,
    input  logic                          inc_endereco_i,
    input  logic                          clr_endereco_i,
    input  logic                          inc_rodada_i,
    input  logic                          conta_led_i,
    input  logic                          conta_tmo_i,
    input  logic                          carrega_jogada_i,
    output logic                          evento_o,
    output logic                          botoes_valido_o,
    output logic                          igual_o,
    output logic                          endereco_fim_o,
    output logic                          ultima_rodada_o,
    output logic                          led_fim_o,
    output logic                          timeout_o,
    output logic [N_BOTOES-1:0]           jogada_o,
    output logic [N_BOTOES-1:0]           mem_dado_o,
    output logic [$clog2(N_RODADAS)-1:0]  rodada_o
);

    localparam int AW = $clog2(N_RODADAS);
    localparam int LW = $clog2(TEMPO_LED + 1);
    localparam logic [N_BOTOES-1:0] PRIMEIRA_OH =
        {{(N_BOTOES-1){1'b0}}, 1'b1} << PRIMEIRA_JOGADA;

    logic [N_BOTOES-1:0] botoes_q;
    logic                or_ant_q;
    logic [N_BOTOES-1:0] jogada_q;
    logic [AW-1:0]       endereco_q, endereco_d;
    logic [AW-1:0]       rodada_q, rodada_d;
    logic [LW-1:0]       led_cnt_q, led_cnt_d;

    logic [N_BOTOES-1:0] mem [N_RODADAS];
    logic [N_BOTOES-1:0] rd_q;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [N_BOTOES-1:0] wdata;

    // The edge detector always runs, so a button held across MOSTRA/APAGA
    // never produces a late event.
    assign evento_o        = (|botoes_q) && !or_ant_q;
    assign botoes_valido_o = eh_one_hot(MAX_BOTOES'(botoes_q));

    always_comb begin
        endereco_d = endereco_q;
        if (limpa_i || clr_endereco_i)
            endereco_d = '0;
        else if (inc_endereco_i)
            endereco_d = endereco_q + 1'b1;

        rodada_d = rodada_q;
        if (limpa_i)
            rodada_d = '0;
        else if (inc_rodada_i)
            rodada_d = rodada_q + 1'b1;

        led_cnt_d = '0;
        if (conta_led_i && !led_fim_o)
            led_cnt_d = led_cnt_q + 1'b1;

        we    = limpa_i || escreve_i;
        waddr = limpa_i ? '0 : rodada_q + 1'b1;
        wdata = limpa_i ? PRIMEIRA_OH : jogada_q;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            botoes_q   <= '0;
            or_ant_q   <= 1'b0;
            jogada_q   <= '0;
            endereco_q <= '0;
            rodada_q   <= '0;
            led_cnt_q  <= '0;
        end else begin
            botoes_q   <= botoes_i;
            or_ant_q   <= |botoes_q;
            if (carrega_jogada_i)
                jogada_q <= botoes_q;
            endereco_q <= endereco_d;
            rodada_q   <= rodada_d;
            led_cnt_q  <= led_cnt_d;
        end
    end

    // Read address is the next endereco with write bypass, so rd_q always
    // holds mem[endereco_q] even in the cycle right after a write.
    always_ff @(posedge clock_i) begin
        if (we)
            mem[waddr] <= wdata;
        if (we && (waddr == endereco_d))
            rd_q <= wdata;
        else
            rd_q <= mem[endereco_d];
    end

`ifdef JOGO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_cnt_d = conta_tmo_i ? tmo_cnt_q + 1'b1 : '0;
    assign timeout_o = conta_tmo_i && (tmo_cnt_q == TW'(TIMEOUT_CICLOS - 1));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            tmo_cnt_q <= '0;
        else
            tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign timeout_o = conta_tmo_i & 1'b0;
`endif

    assign igual_o         = eh_one_hot(MAX_BOTOES'(jogada_q)) && (jogada_q == rd_q);
    assign endereco_fim_o  = (endereco_q == rodada_q);
    assign ultima_rodada_o = (rodada_q == AW'(N_RODADAS - 1));
    assign led_fim_o       = (led_cnt_q == LW'(TEMPO_LED - 1));
    assign jogada_o        = jogada_q;
    assign mem_dado_o      = rd_q;
    assign rodada_o        = rodada_q;

endmodule

// File: rtl/jogo_memoria_param.sv
// Parametrised memory game top: control FSM around jogo_memoria_fd.
// Timeout support is built only when JOGO_TIMEOUT_EN is defined.
module jogo_memoria_param
    import jogo_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int N_RODADAS       = 16,
    parameter int TIMEOUT_CICLOS  = 3000,
    parameter int TEMPO_LED       = 1000,
    parameter int PRIMEIRA_JOGADA = 0
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          iniciar_i,
    input  logic                          modo_i,
    input  logic [N_BOTOES-1:0]           botoes_i,
    output logic [N_BOTOES-1:0]           leds_o,
    output logic                          pronto_o,
    output logic                          ganhou_o,
    output logic                          perdeu_o,
    output logic                          db_timeout_o,
    output logic [ESTADO_W-1:0]           db_estado_o,
    output logic [$clog2(N_RODADAS)-1:0]  db_rodada_o,
    output logic [N_BOTOES-1:0]           db_jogada_o
);

    estado_t estado_q;
    logic    modo_q;
    logic    pronto_q, ganhou_q, perdeu_q, db_timeout_q;

    logic limpa, escreve, inc_endereco, clr_endereco, inc_rodada;
    logic conta_led, conta_tmo, carrega_jogada;
    logic evento, botoes_valido, igual, endereco_fim, ultima_rodada;
    logic led_fim, timeout;
    logic [N_BOTOES-1:0] jogada, mem_dado;

    jogo_memoria_fd #(
        .N_BOTOES        (N_BOTOES),
        .N_RODADAS       (N_RODADAS),
        .TIMEOUT_CICLOS  (TIMEOUT_CICLOS),
        .TEMPO_LED       (TEMPO_LED),
        .PRIMEIRA_JOGADA (PRIMEIRA_JOGADA)
    ) u_fd (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .botoes_i         (botoes_i),
        .limpa_i          (limpa),
        .escreve_i        (escreve),
        .inc_endereco_i   (inc_endereco),
        .clr_endereco_i   (clr_endereco),
        .inc_rodada_i     (inc_rodada),
        .conta_led_i      (conta_led),
        .conta_tmo_i      (conta_tmo),
        .carrega_jogada_i (carrega_jogada),
        .evento_o         (evento),
        .botoes_valido_o  (botoes_valido),
        .igual_o          (igual),
        .endereco_fim_o   (endereco_fim),
        .ultima_rodada_o  (ultima_rodada),
        .led_fim_o        (led_fim),
        .timeout_o        (timeout),
        .jogada_o         (jogada),
        .mem_dado_o       (mem_dado),
        .rodada_o         (db_rodada_o)
    );

    always_comb begin
        limpa          = (estado_q == ST_PREPARA);
        escreve        = (estado_q == ST_ESCREVE);
        inc_rodada     = (estado_q == ST_PROX_RODADA);
        conta_led      = (estado_q == ST_MOSTRA) || (estado_q == ST_APAGA);
        conta_tmo      = (estado_q == ST_ESPERA) || (estado_q == ST_ESPERA_NOVA);
        inc_endereco   = ((estado_q == ST_APAGA) && led_fim && !endereco_fim) ||
                         ((estado_q == ST_COMPARA) && igual && !endereco_fim);
        clr_endereco   = ((estado_q == ST_APAGA) && led_fim && endereco_fim) ||
                         (estado_q == ST_PROX_RODADA);
        carrega_jogada = evento && ((estado_q == ST_ESPERA) ||
                         ((estado_q == ST_ESPERA_NOVA) && botoes_valido));
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            estado_q     <= ST_INICIAL;
            modo_q       <= 1'b0;
            pronto_q     <= 1'b0;
            ganhou_q     <= 1'b0;
            perdeu_q     <= 1'b0;
            db_timeout_q <= 1'b0;
        end else begin
            unique case (estado_q)
                ST_INICIAL:
                    if (iniciar_i) estado_q <= ST_PREPARA;
                ST_PREPARA: begin
                    modo_q   <= modo_i;
                    estado_q <= ST_MOSTRA;
                end
                ST_MOSTRA:
                    if (led_fim) estado_q <= ST_APAGA;
                ST_APAGA:
                    if (led_fim) estado_q <= endereco_fim ? ST_ESPERA : ST_MOSTRA;
                // A press beats a timeout landing on the same cycle.
                ST_ESPERA:
                    if (evento) begin
                        estado_q <= ST_REGISTRA;
                    end else if (timeout) begin
                        estado_q     <= ST_FIM_TIMEOUT;
                        pronto_q     <= 1'b1;
                        perdeu_q     <= 1'b1;
                        db_timeout_q <= 1'b1;
                    end
                ST_REGISTRA:
                    estado_q <= ST_COMPARA;
                ST_COMPARA:
                    if (!igual) begin
                        estado_q <= ST_FIM_ERRO;
                        pronto_q <= 1'b1;
                        perdeu_q <= 1'b1;
                    end else if (!endereco_fim) begin
                        estado_q <= ST_ESPERA;
                    end else if (ultima_rodada) begin
                        estado_q <= ST_FIM_ACERTO;
                        pronto_q <= 1'b1;
                        ganhou_q <= 1'b1;
                    end else begin
                        estado_q <= ST_ESPERA_NOVA;
                    end
                ST_ESPERA_NOVA:
                    if (evento && botoes_valido) begin
                        estado_q <= ST_ESCREVE;
                    end else if (timeout) begin
                        estado_q     <= ST_FIM_TIMEOUT;
                        pronto_q     <= 1'b1;
                        perdeu_q     <= 1'b1;
                        db_timeout_q <= 1'b1;
                    end
                ST_ESCREVE:
                    estado_q <= ST_PROX_RODADA;
                ST_PROX_RODADA:
                    estado_q <= modo_q ? ST_MOSTRA : ST_ESPERA;
                ST_FIM_ACERTO, ST_FIM_ERRO, ST_FIM_TIMEOUT:
                    if (iniciar_i) begin
                        estado_q     <= ST_PREPARA;
                        pronto_q     <= 1'b0;
                        ganhou_q     <= 1'b0;
                        perdeu_q     <= 1'b0;
                        db_timeout_q <= 1'b0;
                    end
                default:
                    estado_q <= ST_INICIAL;
            endcase
        end
    end

    always_comb begin
        leds_o = '0;
        case (estado_q)
            ST_MOSTRA:               leds_o = mem_dado;
            ST_REGISTRA, ST_ESCREVE: leds_o = jogada;
            default:                 leds_o = '0;
        endcase
    end

    assign pronto_o     = pronto_q;
    assign ganhou_o     = ganhou_q;
    assign perdeu_o     = perdeu_q;
    assign db_timeout_o = db_timeout_q;
    assign db_estado_o  = estado_q;
    assign db_jogada_o  = jogada;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed self-checking bench for jogo_memoria_param (4 buttons, 4 rounds).
module tb_jogo_memoria_param;

    localparam int NB  = 4;
    localparam int NR  = 4;
    localparam int TMO = 30;
    localparam int TL  = 3;

    localparam logic [4:0] E_INICIAL = 5'd0,  E_PREPARA = 5'd1,  E_MOSTRA = 5'd2,
                           E_APAGA   = 5'd3,  E_ESPERA  = 5'd4,  E_REGISTRA = 5'd5,
                           E_COMPARA = 5'd6,  E_ESPERA_NOVA = 5'd7, E_ESCREVE = 5'd8,
                           E_ACERTO  = 5'd10, E_ERRO = 5'd11, E_TIMEOUT = 5'd12;

    logic          clk = 1'b0;
    logic          reset, iniciar, modo;
    logic [NB-1:0] botoes;
    logic [NB-1:0] leds, db_jogada;
    logic          pronto, ganhou, perdeu, db_timeout;
    logic [4:0]    db_estado;
    logic [1:0]    db_rodada;

    int checks = 0;
    int errors = 0;

    logic [NB-1:0] seq [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0010};

    jogo_memoria_param #(
        .N_BOTOES(NB), .N_RODADAS(NR), .TIMEOUT_CICLOS(TMO),
        .TEMPO_LED(TL), .PRIMEIRA_JOGADA(0)
    ) dut (
        .clock_i(clk), .reset_i(reset), .iniciar_i(iniciar), .modo_i(modo),
        .botoes_i(botoes), .leds_o(leds), .pronto_o(pronto), .ganhou_o(ganhou),
        .perdeu_o(perdeu), .db_timeout_o(db_timeout), .db_estado_o(db_estado),
        .db_rodada_o(db_rodada), .db_jogada_o(db_jogada)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_state(input string tag, input logic [4:0] st);
        int n = 0;
        while (db_estado !== st && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(db_estado), 32'(st));
    endtask

    task automatic iniciar_jogo(input logic m);
        modo    = m;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check("prepara", 32'(db_estado), 32'(E_PREPARA));
        check("prepara_pronto", 32'(pronto), 32'd0);
    endtask

    // Press v, expect REGISTRA two edges later, then release and let the
    // edge detector settle; exp is the state entered after COMPARA.
    task automatic jogar(input logic [NB-1:0] v, input logic [4:0] exp);
        botoes = v;
        tick();
        tick();
        check("registra", 32'(db_estado), 32'(E_REGISTRA));
        check("registra_jogada", 32'(db_jogada), 32'(v));
        check("registra_leds", 32'(leds), 32'(v));
        tick();
        check("compara", 32'(db_estado), 32'(E_COMPARA));
        botoes = '0;
        tick();
        tick();
        check("pos_compara", 32'(db_estado), 32'(exp));
    endtask

    task automatic nova(input logic [NB-1:0] v);
        botoes = v;
        tick();
        tick();
        check("escreve", 32'(db_estado), 32'(E_ESCREVE));
        check("escreve_leds", 32'(leds), 32'(v));
        botoes = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; iniciar = 1'b0; modo = 1'b0; botoes = '0;
        tick();
        tick();
        check("rst_estado", 32'(db_estado), 32'(E_INICIAL));
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_flags", 32'({pronto, ganhou, perdeu, db_timeout}), 32'd0);
        check("rst_rodada", 32'(db_rodada), 32'd0);
        check("rst_jogada", 32'(db_jogada), 32'd0);
        reset = 1'b0;
        tick();

        // Win in modo 0: only move 0 is displayed, for exactly TL cycles.
        iniciar_jogo(1'b0);
        tick();
        check("mostra0", 32'(db_estado), 32'(E_MOSTRA));
        check("mostra0_leds", 32'(leds), 32'b0001);
        tick();
        tick();
        check("mostra0_fim", 32'(db_estado), 32'(E_MOSTRA));
        tick();
        check("apaga0", 32'(db_estado), 32'(E_APAGA));
        check("apaga0_leds", 32'(leds), 32'd0);
        for (int r = 0; r < 4; r++) begin
            wait_state("win_espera", E_ESPERA);
            check("win_rodada", 32'(db_rodada), 32'(r));
            for (int i = 0; i <= r; i++)
                jogar(seq[i], (i < r) ? E_ESPERA : ((r == 3) ? E_ACERTO : E_ESPERA_NOVA));
            if (r < 3)
                nova(seq[r+1]);
        end
        check("win_ganhou", 32'(ganhou), 32'd1);
        check("win_pronto", 32'(pronto), 32'd1);
        check("win_perdeu", 32'(perdeu), 32'd0);

        // Error in round 2, move 2.
        iniciar_jogo(1'b0);
        check("restart_ganhou", 32'(ganhou), 32'd0);
        wait_state("err_espera1", E_ESPERA);
        jogar(4'b0001, E_ESPERA_NOVA);
        nova(4'b0100);
        wait_state("err_espera2", E_ESPERA);
        jogar(4'b0001, E_ESPERA);
        jogar(4'b0010, E_ERRO);
        check("err_perdeu", 32'(perdeu), 32'd1);
        check("err_pronto", 32'(pronto), 32'd1);
        check("err_timeout", 32'(db_timeout), 32'd0);
        check("err_rodada", 32'(db_rodada), 32'd1);

        // Timeout in round 2, move 2: ESPERA was entered one edge before
        // jogar returns.
        iniciar_jogo(1'b0);
        wait_state("tmo_espera1", E_ESPERA);
        jogar(4'b0001, E_ESPERA_NOVA);
        nova(4'b0100);
        wait_state("tmo_espera2", E_ESPERA);
        jogar(4'b0001, E_ESPERA);
`ifdef JOGO_TIMEOUT_EN
        repeat (TMO - 2) tick();
        check("tmo_antes", 32'(db_estado), 32'(E_ESPERA));
        check("tmo_antes_perdeu", 32'(perdeu), 32'd0);
        tick();
        check("tmo_estado", 32'(db_estado), 32'(E_TIMEOUT));
        check("tmo_perdeu", 32'(perdeu), 32'd1);
        check("tmo_flag", 32'(db_timeout), 32'd1);
        check("tmo_pronto", 32'(pronto), 32'd1);
`else
        repeat (TMO + 5) tick();
        check("sem_tmo_estado", 32'(db_estado), 32'(E_ESPERA));
        check("sem_tmo_flag", 32'(db_timeout), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif

        // modo 1: round 3 replays the whole stored sequence.
        iniciar_jogo(1'b1);
        wait_state("rep_espera1", E_ESPERA);
        jogar(4'b0001, E_ESPERA_NOVA);
        nova(4'b0100);
        wait_state("rep_espera2", E_ESPERA);
        jogar(4'b0001, E_ESPERA);
        jogar(4'b0100, E_ESPERA_NOVA);
        nova(4'b1000);
        wait_state("rep_mostra", E_MOSTRA);
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < TL; c++) begin
                check("rep_led_on", 32'(leds), 32'(seq[i]));
                tick();
            end
            for (int c = 0; c < TL; c++) begin
                check("rep_led_off", 32'(leds), 32'd0);
                tick();
            end
        end
        check("rep_fim", 32'(db_estado), 32'(E_ESPERA));
        check("rep_rodada", 32'(db_rodada), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Held button gives one event; 0011 ignored in ESPERA_NOVA, error in ESPERA.
        iniciar_jogo(1'b0);
        wait_state("held_espera", E_ESPERA);
        botoes = 4'b0001;
        repeat (8) tick();
        check("held_estado", 32'(db_estado), 32'(E_ESPERA_NOVA));
        check("held_jogada", 32'(db_jogada), 32'b0001);
        botoes = '0;
        tick();
        tick();
        botoes = 4'b0011;
        repeat (3) tick();
        check("duplo_nova_estado", 32'(db_estado), 32'(E_ESPERA_NOVA));
        check("duplo_nova_jogada", 32'(db_jogada), 32'b0001);
        botoes = '0;
        tick();
        tick();
        nova(4'b0100);
        wait_state("duplo_espera", E_ESPERA);
        jogar(4'b0011, E_ERRO);
        check("duplo_perdeu", 32'(perdeu), 32'd1);

        // Asynchronous reset from a finished game clears flags at once.
        #2 reset = 1'b1;
        #1;
        check("arst_fim_flags", 32'({pronto, ganhou, perdeu, db_timeout}), 32'd0);
        check("arst_fim_estado", 32'(db_estado), 32'(E_INICIAL));
        reset = 1'b0;
        tick();

        // Asynchronous reset during MOSTRA, then restart from round 1.
        iniciar_jogo(1'b0);
        tick();
        check("arst_mostra_pre", 32'(leds), 32'b0001);
        #2 reset = 1'b1;
        #1;
        check("arst_mostra_leds", 32'(leds), 32'd0);
        check("arst_mostra_estado", 32'(db_estado), 32'(E_INICIAL));
        reset = 1'b0;
        tick();
        iniciar_jogo(1'b0);
        check("restart_rodada", 32'(db_rodada), 32'd0);
        tick();
        check("restart_mostra", 32'(leds), 32'b0001);
        wait_state("restart_espera", E_ESPERA);
        jogar(4'b0001, E_ESPERA_NOVA);
        check("restart_rodada1", 32'(db_rodada), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jogo_memoria_param.md
# jogo_memoria_param

Parametrised successor of the fixed 4-button, 16-round memory game (circuito_exp7 generation). It supports a configurable button count, round count and timeout. The player appends a new move at the end of each round. A runtime `modo` input replays the full stored sequence on the LEDs before every round, a behaviour the previous generation lacks. It sits directly between the board buttons/LEDs and the 7-segment debug decoders.

## Interface
- N_BOTOES, 4: buttons/LEDs; one-hot moves; 2..8
- N_RODADAS, 16: rounds to win; memory depth; power of two, 2..64
- TIMEOUT_CICLOS, 3000: cycles allowed per move
- TEMPO_LED, 1000: cycles each LED shows during display/replay
- PRIMEIRA_JOGADA, 0: index of the button lit as move 0
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- iniciar  in  1  start/restart, level-sensitive in INICIAL and FIM_* states
- modo  in  1  0 = show only move 0 at start; 1 = replay whole sequence each round; sampled in PREPARA
- botoes  in  N_BOTOES  raw buttons, already synchronised
- leds  out  N_BOTOES  displayed move
- pronto, ganhou, perdeu  out  1  end-of-game flags
- db_timeout  out  1  high in FIM_TIMEOUT
- db_estado  out  5  state code
- db_rodada  out  $clog2(N_RODADAS)  current round minus 1
- db_jogada  out  N_BOTOES  last registered move

## Operation
- Memory is an N_RODADAS × N_BOTOES RAM. In PREPARA, entry 0 is written with one-hot PRIMEIRA_JOGADA. Rodada and endereco are cleared.
- States and transitions:
  - INICIAL → PREPARA on iniciar.
  - PREPARA → MOSTRA.
  - MOSTRA lights mem[endereco] for TEMPO_LED cycles. It then goes to APAGA, which lights nothing for TEMPO_LED cycles.
  - In modo=0, MOSTRA runs only in round 1. In modo=1 it runs for endereco 0..rodada each round, then clears endereco.
  - ESPERA → REGISTRA on a press event. REGISTRA → COMPARA.
  - COMPARA on mismatch → FIM_ERRO.
  - COMPARA on match with endereco<rodada → increment endereco, go to ESPERA.
  - COMPARA on match with endereco==rodada and rodada==N_RODADAS-1 → FIM_ACERTO.
  - COMPARA on match with endereco==rodada otherwise → ESPERA_NOVA. A press there goes to ESCREVE, which writes mem[rodada+1].
  - ESCREVE → PROX_RODADA, which increments rodada, clears endereco, then goes to MOSTRA (modo=1) or ESPERA (modo=0).
  - ESPERA/ESPERA_NOVA timeout → FIM_TIMEOUT.
  - FIM_* → PREPARA on iniciar.
- Press event: registered OR(botoes) rises 0→1. The move is botoes registered on that cycle.
  - A non-one-hot value counts as a mismatch in COMPARA.
  - In ESPERA_NOVA a non-one-hot value is ignored and the machine keeps waiting.
- Holding a button produces exactly one event.
- Outputs:
  - FIM_ACERTO: pronto=1, ganhou=1.
  - FIM_ERRO: pronto=1, perdeu=1.
  - FIM_TIMEOUT: pronto=1, perdeu=1, db_timeout=1.
  - All flags are held until PREPARA.
- leds equal mem[endereco] in MOSTRA, db_jogada in REGISTRA/ESCREVE, and 0 otherwise.

## Timing
- Reset clears every output, all counters and db_jogada, and puts the machine in INICIAL. RAM contents are not cleared.
- Reset mid-game aborts immediately. No flags remain set.
- Press detection latency: button rises at edge k → REGISTRA at k+2 → COMPARA at k+3.
- The timeout counter clears on entering ESPERA/ESPERA_NOVA and counts every cycle there.
  - FIM_TIMEOUT is entered on the cycle the count reaches TIMEOUT_CICLOS-1 with no press.
  - If a press and the timeout occur on the same cycle, the press wins.
- A press during MOSTRA/APAGA is ignored. The edge detector still tracks it, so a button held into ESPERA produces no event.
- The LED counter is TEMPO_LED wide enough; it never wraps mid-display.

## Configuration
- JOGO_TIMEOUT_EN:
  - Defined: timeout is active as above.
  - Undefined: the timeout counter is not instantiated, ESPERA waits forever, FIM_TIMEOUT is unreachable and db_timeout is tied 0.

## Structure
- Package jogo_pkg holds the state enum, its 5-bit encoding (db_estado values), and the one-hot validity function.
- One sub-module, jogo_memoria_fd (datapath), holds the RAM, rodada/endereco counters, LED and timeout counters, edge detector and comparator. The top holds the FSM.

## Test plan
- Win, N_BOTOES=4, N_RODADAS=4, modo=0, PRIMEIRA_JOGADA=0:
  - Stimulus: rounds use 0001; 0001,0100; 0001,0100,1000; 0001,0100,1000,0010, each followed by the new move.
  - Required: ganhou=1, pronto=1, perdeu=0 after the final COMPARA.
- Error in round 2, move 2: play 0001, new 0100, then 0001, 0010.
  - Required: perdeu=1, db_timeout=0, db_rodada=1.
- Timeout in round 2, move 2, with JOGO_TIMEOUT_EN: after 0001, 0100, 0001, no press.
  - Required: perdeu=1 and db_timeout=1 exactly TIMEOUT_CICLOS cycles after entering ESPERA.
- modo=1 replay: in round 3, leds show 0001, 0100, 1000 for TEMPO_LED cycles each, separated by TEMPO_LED cycles of 0.
- Held button and simultaneous 0011:
  - A held 0001 yields one event.
  - 0011 in ESPERA → perdeu.
  - 0011 in ESPERA_NOVA → ignored.
- Reset asserted in MOSTRA: all outputs 0 asynchronously. Then iniciar restarts the game at round 1.
